// File: rtl/rvm_pkg.sv
// Shared definitions for the reverse vending machine blocks.
// Holds the sequencer state encoding and the default timing constants.
package rvm_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_CLASSIFY = 3'd2;
    localparam logic [2:0] ST_ACCEPT   = 3'd3;
    localparam logic [2:0] ST_REJECT   = 3'd4;
    localparam logic [2:0] ST_CLEAR    = 3'd5;
    localparam logic [2:0] ST_REWARD   = 3'd6;

    localparam int DEBOUNCE_CYC_DEF  = 4;
    localparam int CLASS_TIMEOUT_DEF = 16;
    localparam int GATE_CYC_DEF      = 8;
    localparam int BOTTLES_MAX_DEF   = 10;
    localparam int CNT_W_DEF         = 4;

endpackage

// File: rtl/rvm_bottle_sequencer_if.sv
// Bottle path signals between the sequencer and its surroundings.
// The master modport is the sequencer side; the slave modport is the machine side.
interface rvm_bottle_sequencer_if
    import rvm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             bottle_sense;
    logic             valid_bottle;
    logic             invalid_bottle;
    logic             user_done;
    logic             reward_ack;
    logic             bc_pulse;
    logic             gate_open;
    logic             reject_open;
    logic [CNT_W-1:0] bottle_cnt;
    logic             reward_req;
    logic             timeout_flt;
    logic             busy;

    modport master (
        input  bottle_sense,
        input  valid_bottle,
        input  invalid_bottle,
        input  user_done,
        input  reward_ack,
        output bc_pulse,
        output gate_open,
        output reject_open,
        output bottle_cnt,
        output reward_req,
        output timeout_flt,
        output busy
    );

    modport slave (
        output bottle_sense,
        output valid_bottle,
        output invalid_bottle,
        output user_done,
        output reward_ack,
        input  bc_pulse,
        input  gate_open,
        input  reject_open,
        input  bottle_cnt,
        input  reward_req,
        input  timeout_flt,
        input  busy
    );

endinterface

// File: rtl/rvm_sync_debounce.sv
// Two-flop synchronizer for the raw bottle sensor plus a consecutive-high counter.
// qualified fires on the DEBOUNCE_CYC-th consecutive synced-high cycle while enabled.
module rvm_sync_debounce
    import rvm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sense,
    input  logic enable,
    output logic sns,
    output logic qualified
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    logic          meta;
    logic [DW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sns  <= 1'b0;
        end else begin
            meta <= sense;
            sns  <= meta;
        end
    end

    // Any low sample, or leaving the debounce window, restarts the run from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || !sns) begin
            count <= '0;
        end else if (count != DW'(DEBOUNCE_CYC)) begin
            count <= count + 1'b1;
        end
    end

    assign qualified = enable && sns && (count == DW'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/rvm_bottle_sequencer.sv
// Top-level sequencer of the reverse vending machine bottle path: debounce, classify,
// gate or flap, session count and reward request. All outputs are registered.
module rvm_bottle_sequencer
    import rvm_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int CLASS_TIMEOUT = CLASS_TIMEOUT_DEF,
    parameter int GATE_CYC      = GATE_CYC_DEF,
    parameter int BOTTLES_MAX   = BOTTLES_MAX_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rvm_bottle_sequencer_if.master seq
);

    localparam int TMAX = (CLASS_TIMEOUT > GATE_CYC) ? CLASS_TIMEOUT : GATE_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    generate
        if (BOTTLES_MAX >= (1 << CNT_W)) begin : g_cnt_w_check
            $error("BOTTLES_MAX must be below 2**CNT_W");
        end
    endgenerate

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] count;
    logic             sns;
    logic             qualified;
    logic             class_timeout;
    logic             accept_entry;
    logic             bc_pulse;
    logic             gate_open;
    logic             reject_open;
    logic             reward_req;
    logic             timeout_flt;
    logic             busy;

    rvm_sync_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_sync_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .sense     (seq.bottle_sense),
        .enable    ((state == ST_IDLE) || (state == ST_DEBOUNCE)),
        .sns       (sns),
        .qualified (qualified)
    );

    // A reject verdict wins over a simultaneous accept; the timeout is the fallback.
    always_comb begin
        next_state    = state;
        class_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sns) begin
                    next_state = ST_DEBOUNCE;
                end else if (seq.user_done && (count != '0)) begin
                    next_state = ST_REWARD;
                end
            end
            ST_DEBOUNCE: begin
                if (!sns) begin
                    next_state = ST_IDLE;
                end else if (qualified) begin
                    next_state = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (seq.invalid_bottle) begin
                    next_state = ST_REJECT;
                end else if (seq.valid_bottle) begin
                    next_state = ST_ACCEPT;
                end else if (timer == '0) begin
                    next_state    = ST_REJECT;
                    class_timeout = 1'b1;
                end
            end
            ST_ACCEPT, ST_REJECT: begin
                if (timer == '0) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (!sns) begin
                    next_state = (count == CNT_W'(BOTTLES_MAX)) ? ST_REWARD : ST_IDLE;
                end
            end
            ST_REWARD: begin
                if (seq.reward_ack) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign accept_entry = (next_state == ST_ACCEPT) && (state != ST_ACCEPT);

    // Outputs follow next_state so each lands in the same cycle as the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            count       <= '0;
            bc_pulse    <= 1'b0;
            gate_open   <= 1'b0;
            reject_open <= 1'b0;
            reward_req  <= 1'b0;
            timeout_flt <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != ST_IDLE);
            gate_open   <= (next_state == ST_ACCEPT);
            reject_open <= (next_state == ST_REJECT);
            reward_req  <= (next_state == ST_REWARD);
            bc_pulse    <= accept_entry;
            timeout_flt <= class_timeout;

            if (next_state != state) begin
                case (next_state)
                    ST_CLASSIFY:          timer <= TW'(CLASS_TIMEOUT - 1);
                    ST_ACCEPT, ST_REJECT: timer <= TW'(GATE_CYC - 1);
                    default:              timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            if (accept_entry && (count != CNT_W'(BOTTLES_MAX))) begin
                count <= count + 1'b1;
            end else if ((state == ST_REWARD) && seq.reward_ack) begin
                count <= '0;
            end
        end
    end

    assign seq.bc_pulse    = bc_pulse;
    assign seq.gate_open   = gate_open;
    assign seq.reject_open = reject_open;
    assign seq.bottle_cnt  = count;
    assign seq.reward_req  = reward_req;
    assign seq.timeout_flt = timeout_flt;
    assign seq.busy        = busy;

endmodule
